// File: rtl/uart_status_reporter.sv
// Formats I/O-expander samples into ASCII lines ("P0=xx P1=yy\r\n") after an optional banner, for uart_tx.
// Latency: the first tx_send comes 2 cycles after a sample reaches IDLE, and 2 cycles after tx_ready rises in DRAIN.
// Backpressure: each byte waits for tx_ready. A newer sample overwrites the one pending and is counted in overrun_count.
// Optional: UART_REPORT_CHANGES_ONLY_EN drops samples identical to the last line sent.
module uart_status_reporter #(
  parameter bit HEX_UPPERCASE = 1'b1,
  parameter bit BANNER_EN     = 1'b1
) (
  input  logic       clk48,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample_port0,
  input  logic [7:0] sample_port1,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic       busy,
  output logic [7:0] overrun_count
);

  typedef enum logic [2:0] {ST_START, ST_IDLE, ST_LOAD, ST_SEND, ST_DRAIN} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic       src_line, src_line_nxt;
  logic [7:0] tx_data_nxt;
  logic       tx_send_nxt;
  logic [7:0] pend_p0, pend_p1, line_p0, line_p1;
  logic       pend_vld;
  logic       consume, start_line, dup;
  logic [7:0] cur_byte;
  logic [3:0] last_idx;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (HEX_UPPERCASE ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  function automatic logic [7:0] banner_byte(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h4D;
      4'd1:    return 8'h45;
      4'd2:    return 8'h47;
      4'd3:    return 8'h41;
      4'd4:    return 8'h70;
      4'd5:    return 8'h68;
      4'd6:    return 8'h6F;
      4'd7:    return 8'h6E;
      4'd8:    return 8'h65;
      4'd9:    return 8'h20;
      4'd10:   return 8'h43;
      4'd11:   return 8'h54;
      4'd12:   return 8'h4C;
      4'd13:   return 8'h30;
      4'd14:   return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic logic [7:0] line_byte(input logic [3:0] i, input logic [7:0] p0,
                                           input logic [7:0] p1);
    case (i)
      4'd0:    return 8'h50;
      4'd1:    return 8'h30;
      4'd2:    return 8'h3D;
      4'd3:    return hex_char(p0[7:4]);
      4'd4:    return hex_char(p0[3:0]);
      4'd5:    return 8'h20;
      4'd6:    return 8'h50;
      4'd7:    return 8'h31;
      4'd8:    return 8'h3D;
      4'd9:    return hex_char(p1[7:4]);
      4'd10:   return hex_char(p1[3:0]);
      4'd11:   return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign cur_byte = src_line ? line_byte(idx, line_p0, line_p1) : banner_byte(idx);
  assign last_idx = src_line ? 4'd12 : 4'd15;
  assign busy     = (state == ST_LOAD) || (state == ST_SEND) || (state == ST_DRAIN);

`ifdef UART_REPORT_CHANGES_ONLY_EN
  logic [7:0] last_p0, last_p1;

  assign dup = (pend_p0 == last_p0) && (pend_p1 == last_p1);

  always_ff @(posedge clk48) begin
    if (reset) begin
      last_p0 <= 8'hFF;
      last_p1 <= 8'hFF;
    end else if (start_line) begin
      last_p0 <= pend_p0;
      last_p1 <= pend_p1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    src_line_nxt = src_line;
    tx_data_nxt  = tx_data;
    tx_send_nxt  = tx_send;
    consume      = 1'b0;
    start_line   = 1'b0;
    case (state)
      ST_START: begin
        idx_nxt      = 4'd0;
        src_line_nxt = 1'b0;
        state_nxt    = BANNER_EN ? ST_LOAD : ST_IDLE;
      end
      ST_IDLE: begin
        if (pend_vld) begin
          consume = 1'b1;
          if (!dup) begin
            start_line   = 1'b1;
            src_line_nxt = 1'b1;
            idx_nxt      = 4'd0;
            state_nxt    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        tx_data_nxt = cur_byte;
        if (tx_ready) begin
          tx_send_nxt = 1'b1;
          state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        // Hold the request until uart_tx drops READY to confirm it took the byte.
        if (!tx_ready) begin
          tx_send_nxt = 1'b0;
          state_nxt   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tx_ready) begin
          if (idx == last_idx) begin
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = ST_LOAD;
          end
        end
      end
      default: state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      state    <= ST_START;
      idx      <= 4'd0;
      src_line <= 1'b0;
      tx_data  <= 8'h00;
      tx_send  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      src_line <= src_line_nxt;
      tx_data  <= tx_data_nxt;
      tx_send  <= tx_send_nxt;
    end
  end

  // A sample replacing one that IDLE is consuming in the same cycle is not an overrun.
  always_ff @(posedge clk48) begin
    if (reset) begin
      pend_vld      <= 1'b0;
      pend_p0       <= 8'h00;
      pend_p1       <= 8'h00;
      line_p0       <= 8'h00;
      line_p1       <= 8'h00;
      overrun_count <= 8'h00;
    end else begin
      if (sample_valid) begin
        pend_p0  <= sample_port0;
        pend_p1  <= sample_port1;
        pend_vld <= 1'b1;
        if (pend_vld && !consume && (overrun_count != 8'hFF))
          overrun_count <= overrun_count + 8'd1;
      end else if (consume) begin
        pend_vld <= 1'b0;
      end
      if (start_line) begin
        line_p0 <= pend_p0;
        line_p1 <= pend_p1;
      end
    end
  end

endmodule
